// File: rtl/wb_capture.sv
// Writeback capture stage: latches a result source, waits for load data when needed,
// and drives a one-cycle register-file write. Optional forwarding port: WB_CAPTURE_FWD_EN.
module wb_capture #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic [1:0]  SEL,
    input  logic [31:0] Dato_Alu,
    input  logic [9:0]  Dato_Pc,
    input  logic [31:0] Dato_Imm,
    input  logic [4:0]  Rd,
    input  logic        Reg_We,
    output logic        Mem_Req,
    input  logic        Mem_Valid,
    input  logic [31:0] Mem_Dato,
    output logic        Wr_En,
    output logic [4:0]  Wr_Addr,
    output logic [31:0] Wr_Dato,
`ifdef WB_CAPTURE_FWD_EN
    output logic        Fwd_Valid,
    output logic [4:0]  Fwd_Addr,
    output logic [31:0] Fwd_Dato,
`endif
    output logic        Busy,
    output logic        Err
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    state_t     state;
    logic [9:0] tmo_cnt;
    logic       reg_we_p0;

    // The memory source (01) is filled in later from Mem_Dato, so it never comes through here.
    function automatic logic [31:0] sel_operand(input logic [1:0]  s,
                                                input logic [31:0] alu,
                                                input logic [9:0]  pc,
                                                input logic [31:0] imm);
        case (s)
            2'b00:   sel_operand = alu;
            2'b10:   sel_operand = {22'b0, pc};
            2'b11:   sel_operand = imm;
            default: sel_operand = 32'b0;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            In_Ready  <= 1'b1;
            Mem_Req   <= 1'b0;
            Wr_En     <= 1'b0;
            Wr_Addr   <= 5'b0;
            Wr_Dato   <= 32'b0;
            Busy      <= 1'b0;
            Err       <= 1'b0;
            tmo_cnt   <= 10'b0;
            reg_we_p0 <= 1'b0;
        end else begin
            Err   <= 1'b0;
            Wr_En <= 1'b0;
            case (state)
                IDLE: begin
                    if (In_Valid) begin
                        Wr_Addr   <= Rd;
                        reg_we_p0 <= Reg_We;
                        In_Ready  <= 1'b0;
                        Busy      <= 1'b1;
                        if (SEL == 2'b01) begin
                            state   <= WAIT_MEM;
                            Mem_Req <= 1'b1;
                            tmo_cnt <= 10'b0;
                        end else begin
                            state   <= WRITE;
                            Wr_Dato <= sel_operand(SEL, Dato_Alu, Dato_Pc, Dato_Imm);
                            Wr_En   <= Reg_We && (Rd != 5'd0);
                        end
                    end
                end
                WAIT_MEM: begin
                    // Load data wins over a timeout landing in the same cycle.
                    if (Mem_Valid) begin
                        state   <= WRITE;
                        Mem_Req <= 1'b0;
                        Wr_Dato <= Mem_Dato;
                        Wr_En   <= reg_we_p0 && (Wr_Addr != 5'd0);
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= IDLE;
                        Mem_Req  <= 1'b0;
                        In_Ready <= 1'b1;
                        Busy     <= 1'b0;
                        Err      <= 1'b1;
                        tmo_cnt  <= 10'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
                WRITE: begin
                    state    <= IDLE;
                    In_Ready <= 1'b1;
                    Busy     <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    In_Ready <= 1'b1;
                    Mem_Req  <= 1'b0;
                    Busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_CAPTURE_FWD_EN
    assign Fwd_Valid = Wr_En;
    assign Fwd_Addr  = Wr_Addr;
    assign Fwd_Dato  = Wr_Dato;
`endif

endmodule
